// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, the arbiter and the async-FIFO write side.
// The urgent vector exists only when FIFO_WR_ARB_URGENT_EN is defined.
interface fifo_wr_arbiter_if #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned d_width = 8
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*d_width-1:0] req_data;
    logic                     full;
`ifdef FIFO_WR_ARB_URGENT_EN
    logic [N_REQ-1:0]         urgent;
`endif
    logic [N_REQ-1:0]         grant;
    logic [N_REQ-1:0]         ack;
    logic                     w_en;
    logic [d_width-1:0]       wdata;
    logic                     busy;

`ifdef FIFO_WR_ARB_URGENT_EN
    modport master (
        output req, req_data, full, urgent,
        input  grant, ack, w_en, wdata, busy
    );
    modport slave (
        input  req, req_data, full, urgent,
        output grant, ack, w_en, wdata, busy
    );
`else
    modport master (
        output req, req_data, full,
        input  grant, ack, w_en, wdata, busy
    );
    modport slave (
        input  req, req_data, full,
        output grant, ack, w_en, wdata, busy
    );
`endif
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one async-FIFO write port (wclk domain).
// Define FIFO_WR_ARB_URGENT_EN to restrict arbitration to urgent requesters when any are pending.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned d_width   = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic             wclk,
    input  logic             reset,
    fifo_wr_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last_owner;
    logic [CNT_W-1:0]   r_beat_cnt;

    state_e             w_state_nxt;
    logic [N_REQ-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [IDX_W-1:0]   w_last_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [N_REQ-1:0]   w_elig;
    logic [IDX_W-1:0]   w_start;
    logic [2*N_REQ-1:0] w_elig_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_rot_pos;
    logic [IDX_W:0]     w_sum;
    logic [IDX_W-1:0]   w_pick;
    logic [N_REQ-1:0]   w_pick_onehot;
    logic               w_busy;
    logic               w_owner_req;
    logic               w_beat;
    logic               w_last_beat;
    logic [d_width-1:0] w_wdata;

`ifdef FIFO_WR_ARB_URGENT_EN
    logic [N_REQ-1:0]   w_urg;
    assign w_urg  = bus.req & bus.urgent;
    assign w_elig = (|w_urg) ? w_urg : bus.req;
`else
    assign w_elig = bus.req;
`endif

    // Rotate so the requester after the last owner sits at bit 0, then take the lowest set bit.
    assign w_start    = (r_last_owner == IDX_W'(N_REQ - 1)) ? '0 : r_last_owner + 1'b1;
    assign w_elig_dbl = {w_elig, w_elig} >> w_start;
    assign w_rot      = w_elig_dbl[N_REQ-1:0];

    always_comb begin
        w_rot_pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_rot_pos = IDX_W'(i);
            end
        end
    end

    assign w_sum  = {1'b0, w_start} + {1'b0, w_rot_pos};
    assign w_pick = (w_sum >= (IDX_W + 1)'(N_REQ)) ? IDX_W'(w_sum - (IDX_W + 1)'(N_REQ))
                                                   : IDX_W'(w_sum);
    assign w_pick_onehot = {{(N_REQ - 1){1'b0}}, 1'b1} << w_pick;

    assign w_busy      = (r_state == StBusy);
    assign w_owner_req = bus.req[r_owner];
    assign w_beat      = w_busy & w_owner_req & ~bus.full;
    assign w_last_beat = (r_beat_cnt == CNT_W'(BURST_LEN - 1));

    // Grant is one-hot or zero, so an AND-OR mux selects the owner's data or yields 0 when idle.
    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_wdata = w_wdata | bus.req_data[i*d_width +: d_width];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        w_cnt_nxt   = r_beat_cnt;
        unique case (r_state)
            StIdle: begin
                if (|w_elig) begin
                    w_state_nxt = StBusy;
                    w_owner_nxt = w_pick;
                    w_grant_nxt = w_pick_onehot;
                    w_cnt_nxt   = '0;
                end
            end
            StBusy: begin
                if (!w_owner_req) begin
                    w_state_nxt = StIdle;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_owner;
                end else if (w_beat) begin
                    w_cnt_nxt = r_beat_cnt + 1'b1;
                    if (w_last_beat) begin
                        w_state_nxt = StIdle;
                        w_grant_nxt = '0;
                        w_last_nxt  = r_owner;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(N_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_beat_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.grant = r_grant;
    assign bus.busy  = w_busy;
    assign bus.w_en  = w_beat;
    assign bus.ack   = w_beat ? r_grant : '0;
    assign bus.wdata = w_wdata;

    a_no_write_when_full: assert property (@(posedge wclk) !(bus.w_en && bus.full));
    a_ack_onehot0:        assert property (@(posedge wclk) $onehot0(bus.ack));
    a_grant_onehot0:      assert property (@(posedge wclk) disable iff (reset) $onehot0(r_grant));
    a_burst_bound:        assert property (@(posedge wclk) disable iff (reset)
                                           r_beat_cnt <= CNT_W'(BURST_LEN));
endmodule
